// File: rtl/data_array_arbiter.sv
// Shares the single-port L1 data-array SRAM between a write and a read requester.
// Define DATA_ARRAY_INIT_EN to zero the whole array after every reset.
module data_array_arbiter #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 256,
  parameter int unsigned MASK_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [MASK_W-1:0] sram_wmask,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned SC_W = 4;
  localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

  logic              in_init;
  logic [ADDR_W-1:0] sweep_addr;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              rsp_valid_q;
  logic              force_rd;
  logic              rd_fire, wr_fire;

`ifdef DATA_ARRAY_INIT_EN
  typedef enum logic {S_INIT, S_IDLE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (state_q == S_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (&init_cnt_q) begin
        state_d     = S_IDLE;
        init_done_d = 1'b1;
      end
    end
  end

  assign in_init    = (state_q == S_INIT);
  assign sweep_addr = init_cnt_q;
  assign init_done  = init_done_q;
`else
  assign in_init    = 1'b0;
  assign sweep_addr = '0;
  assign init_done  = 1'b1;
`endif

  always_comb begin
    rd_ready   = 1'b0;
    wr_ready   = 1'b0;
    force_rd   = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (in_init) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = sweep_addr;
      sram_wmask = '1;
    end else begin
      // Writes win unless a read has waited STARVE_LIMIT write grants.
      force_rd = rd_valid & (starve_q == LIMIT);
      wr_ready = ~force_rd;
      rd_ready = ~wr_valid | force_rd;
      if (wr_valid && wr_ready) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = wr_addr;
        sram_wdata = wr_data;
        sram_wmask = wr_mask;
      end else if (rd_valid && rd_ready) begin
        sram_en   = 1'b1;
        sram_addr = rd_addr;
      end
    end
  end

  assign wr_fire = wr_valid & wr_ready;
  assign rd_fire = rd_valid & rd_ready;

  always_comb begin
    starve_d = starve_q;
    if (!rd_valid || rd_fire)
      starve_d = '0;
    else if (wr_fire && starve_q != LIMIT)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      rsp_valid_q <= rd_fire;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_valid_q ? sram_rdata : '0;

endmodule

// File: tb/tb_data_array_arbiter.sv
// Directed bench for data_array_arbiter with a byte-masked SRAM model.
// Covers the init sweep only when DATA_ARRAY_INIT_EN is defined.
module tb_data_array_arbiter;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         rd_valid, rd_ready;
  logic [8:0]   rd_addr;
  logic         wr_valid, wr_ready;
  logic [8:0]   wr_addr;
  logic [255:0] wr_data;
  logic [31:0]  wr_mask;
  logic         rsp_valid;
  logic [255:0] rsp_data;
  logic         init_done;
  logic [8:0]   sram_addr;
  logic         sram_en, sram_wmode;
  logic [255:0] sram_wdata, sram_rdata;
  logic [31:0]  sram_wmask;

  int n_chk = 0;
  int n_err = 0;

  logic [255:0] mem [512];

  data_array_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask),
    .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int b = 0; b < 32; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic rv, input logic [8:0] ra,
                        input logic wv, input logic [8:0] wa,
                        input logic [255:0] wd, input logic [31:0] wm);
    rd_valid = rv; rd_addr = ra;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
  endtask

  task automatic drive(input logic rv, input logic [8:0] ra,
                       input logic wv, input logic [8:0] wa,
                       input logic [255:0] wd, input logic [31:0] wm);
    @(negedge clock);
    set_in(rv, ra, wv, wa, wd, wm);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 9'd0, 1'b0, 9'd0, '0, '0);
  endtask

  logic [255:0] a5, ones, pat;
  string        exp_g;
  logic         prev_r;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {8{32'hDEAD_BEEF}};
    sram_rdata = '0;
    reset_n = 1'b0;
    set_in(1'b0, 9'd0, 1'b0, 9'd0, '0, '0);
    a5   = {32{8'hA5}};
    ones = '1;
    #12;
    check("rst_rsp_valid", 256'(rsp_valid), 256'd0);
    check("rst_rsp_data", rsp_data, '0);

`ifdef DATA_ARRAY_INIT_EN
    check("rst_init_done", 256'(init_done), 256'd0);
    @(negedge clock);
    reset_n = 1'b1;
    set_in(1'b1, 9'd4, 1'b1, 9'd8, ones, '1);
    for (int i = 0; i <= 200; i++) begin
      if (i > 0) drive(1'b1, 9'd4, 1'b1, 9'd8, ones, '1);
      check("sweep1_addr", 256'(sram_addr), 256'(i));
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) drive(1'b1, 9'd4, 1'b1, 9'd8, ones, '1);
      check("sweep_addr", 256'(sram_addr), 256'(i));
      check("sweep_ctl", 256'({sram_en, sram_wmode, rd_ready, wr_ready,
                               init_done}), 256'(5'b11000));
      check("sweep_mask", 256'(sram_wmask), 256'(32'hFFFF_FFFF));
    end
    idle();
    check("init_done_512", 256'(init_done), 256'd1);
    drive(1'b1, 9'd77, 1'b0, 9'd0, '0, '0);
    idle();
    check("post_init_zero", rsp_data, '0);
    check("post_init_rspv", 256'(rsp_valid), 256'd1);
    for (int i = 0; i < 512; i++) mem[i] = '0;
`else
    check("rst_init_done", 256'(init_done), 256'd1);
    @(negedge clock);
    reset_n = 1'b1;
    set_in(1'b1, 9'd5, 1'b0, 9'd0, '0, '0);
    #1;
    check("first_rd_ready", 256'(rd_ready), 256'd1);
    check("first_rd_sram", 256'({sram_en, sram_wmode, sram_addr}),
          256'({1'b1, 1'b0, 9'd5}));
    idle();
    check("first_rsp_valid", 256'(rsp_valid), 256'd1);
    check("first_rsp_data", rsp_data, {8{32'hDEAD_BEEF}});
`endif

    idle();
    check("idle_sram", 256'({sram_en, sram_wmode, sram_addr, sram_wmask}),
          256'd0);
    check("idle_wdata", sram_wdata, '0);
    check("idle_rsp_valid", 256'(rsp_valid), 256'd0);

    drive(1'b0, 9'd0, 1'b1, 9'h1A5, a5, '1);
    check("wr_ready", 256'(wr_ready), 256'd1);
    check("wr_sram_ctl", 256'({sram_en, sram_wmode, sram_addr}),
          256'({1'b1, 1'b1, 9'h1A5}));
    check("wr_sram_data", sram_wdata, a5);
    check("wr_sram_mask", 256'(sram_wmask), 256'(32'hFFFF_FFFF));
    drive(1'b1, 9'h1A5, 1'b0, 9'd0, '0, '0);
    check("rd_sram_ctl", 256'({sram_en, sram_wmode, sram_addr, sram_wmask}),
          256'({1'b1, 1'b0, 9'h1A5, 32'd0}));
    check("rd_sram_wdata", sram_wdata, '0);
    idle();
    check("lat_rsp_valid", 256'(rsp_valid), 256'd1);
    check("lat_rsp_data", rsp_data, a5);
    idle();
    check("gap_rsp_valid", 256'(rsp_valid), 256'd0);
    check("gap_rsp_data_zero", rsp_data, '0);

    drive(1'b0, 9'd0, 1'b1, 9'd3, ones, '1);
    drive(1'b0, 9'd0, 1'b1, 9'd3, '0, 32'h0000_0001);
    drive(1'b1, 9'd3, 1'b0, 9'd0, '0, '0);
    idle();
    check("mask_rsp", rsp_data, {{248{1'b1}}, 8'h00});

    drive(1'b0, 9'd0, 1'b1, 9'd9, '0, '0);
    check("ind_rd_ready_wv", 256'({rd_ready, wr_ready}), 256'(2'b01));
    drive(1'b0, 9'd0, 1'b0, 9'd0, '0, '0);
    check("ind_ready_none", 256'({rd_ready, wr_ready}), 256'(2'b11));
    drive(1'b1, 9'd9, 1'b0, 9'd0, '0, '0);
    check("ind_ready_rv", 256'({rd_ready, wr_ready}), 256'(2'b11));
    idle();

    exp_g  = "WWWWRWWWWR";
    prev_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 9'h1A5, 1'b1, 9'd10, '1, '1);
      check("starve_grant", 256'({rd_ready, wr_ready}),
            (exp_g[i] == "R") ? 256'(2'b10) : 256'(2'b01));
      check("starve_rsp", 256'(rsp_valid), 256'(prev_r));
      prev_r = (exp_g[i] == "R");
    end
    idle();
    check("starve_rsp_data", rsp_data, a5);

    drive(1'b1, 9'd0, 1'b1, 9'd10, '1, '1);
    drive(1'b1, 9'd0, 1'b1, 9'd10, '1, '1);
    drive(1'b0, 9'd0, 1'b1, 9'd10, '1, '1);
    exp_g = "WWWWR";
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'd0, 1'b1, 9'd10, '1, '1);
      check("clr_grant", 256'({rd_ready, wr_ready}),
            (exp_g[i] == "R") ? 256'(2'b10) : 256'(2'b01));
    end

    drive(1'b1, 9'h1A5, 1'b0, 9'd0, '0, '0);
    drive(1'b1, 9'd3, 1'b0, 9'd0, '0, '0);
    check("b2b_rsp0", rsp_data, a5);
    drive(1'b1, 9'h1A5, 1'b0, 9'd0, '0, '0);
    check("b2b_rsp1", rsp_data, {{248{1'b1}}, 8'h00});
    idle();
    check("b2b_rsp2", rsp_data, a5);
    check("b2b_valid2", 256'(rsp_valid), 256'd1);

    drive(1'b1, 9'h1A5, 1'b0, 9'd0, '0, '0);
    @(posedge clock);
    #1;
    set_in(1'b0, 9'd0, 1'b0, 9'd0, '0, '0);
    reset_n = 1'b0;
    #1;
    check("rst_drop_rsp", 256'(rsp_valid), 256'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_drop_rsp2", 256'(rsp_valid), 256'd0);
    check("rst_drop_data", rsp_data, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
